// File: rtl/fp_mul_pkg.sv
// Shared types and limits for the FP multiplier arbiter.
package fp_mul_pkg;

    typedef logic [31:0] fp32_t;
    typedef logic [2:0]  rmode_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;

    localparam int MUL_LAT_MAX = 15;

endpackage

// File: rtl/fp_mul_arbiter_rr_arb2.sv
// Two-way round-robin grant: ptr picks the winner only when both request.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP multiplier between two requesters; one operation in flight,
// round-robin grant, operands held for MUL_LAT cycles, result held until consumed.
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  fp32_t [1:0]   req_x,
    input  fp32_t [1:0]   req_y,
    input  rmode_t [1:0]  req_rmode,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output fp32_t         rsp_z,
    output logic          rsp_ovrf,
    output logic          rsp_udrf,
    output logic          mul_valid,
    output fp32_t         mul_x,
    output fp32_t         mul_y,
    output rmode_t        mul_rmode,
    input  fp32_t         mul_z,
    input  logic          mul_ovrf,
    input  logic          mul_udrf
);

    localparam logic [3:0] LAT4 = 4'(MUL_LAT);

    arb_state_e state;
    logic [3:0] cnt;
    logic       owner;
    logic       ptr;
    logic [1:0] gnt;
    logic       g;

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign g = gnt[1];

    always_comb begin
        req_ready = (state == IDLE) ? gnt : 2'b00;
        rsp_valid = 2'b00;
        if (state == DONE) rsp_valid[owner] = 1'b1;
        mul_valid = (state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            ptr       <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            mul_rmode <= '0;
            rsp_z     <= '0;
            rsp_ovrf  <= 1'b0;
            rsp_udrf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt != 2'b00) begin
                    mul_x     <= req_x[g];
                    mul_y     <= req_y[g];
                    mul_rmode <= req_rmode[g];
                    owner     <= g;
                    cnt       <= LAT4;
                    state     <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    // Final latency cycle: multiplier output is valid now.
                    if (cnt == 4'd1) begin
                        rsp_z    <= mul_z;
                        rsp_ovrf <= mul_ovrf;
                        rsp_udrf <= mul_udrf;
                        state    <= DONE;
                    end
                end
                DONE: if (rsp_ready[owner]) begin
                    ptr   <= ~owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench: two arbiters (MUL_LAT 1 and 4), each with a behavioural multiplier model.
module tb_fp_mul_arbiter;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] z;
        logic        o;
        logic        u;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errs = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t sb_b[$];

    // instance a: MUL_LAT = 1
    logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0][31:0] req_x, req_y;
    logic [1:0][2:0]  req_rmode;
    logic [31:0]      rsp_z, mul_x, mul_y, mul_z;
    logic             rsp_ovrf, rsp_udrf, mul_valid, mul_ovrf, mul_udrf;
    logic [2:0]       mul_rmode;
    logic [3:0]       mc;

    // instance b: MUL_LAT = 4
    logic [1:0]       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [1:0][31:0] b_req_x, b_req_y;
    logic [1:0][2:0]  b_req_rmode;
    logic [31:0]      b_rsp_z, b_mul_x, b_mul_y, b_mul_z;
    logic             b_rsp_ovrf, b_rsp_udrf, b_mul_valid, b_mul_ovrf, b_mul_udrf;
    logic [2:0]       b_mul_rmode;
    logic [3:0]       b_mc;

    fp_mul_arbiter #(.MUL_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf),
        .mul_valid(mul_valid), .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode),
        .mul_z(mul_z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf)
    );

    fp_mul_arbiter #(.MUL_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_x(b_req_x), .req_y(b_req_y), .req_rmode(b_req_rmode),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_z(b_rsp_z), .rsp_ovrf(b_rsp_ovrf), .rsp_udrf(b_rsp_udrf),
        .mul_valid(b_mul_valid), .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_rmode(b_mul_rmode),
        .mul_z(b_mul_z), .mul_ovrf(b_mul_ovrf), .mul_udrf(b_mul_udrf)
    );

    // Truncating single-precision multiply; subnormal inputs flush to zero. Returns {z, ovrf, udrf}.
    function automatic logic [33:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          e;
        logic [47:0] m;
        logic [22:0] f;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0)
            return {s, 31'd0, 1'b0, (x[30:0] != 31'd0) && (y[30:0] != 31'd0)};
        m = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (m[47]) begin
            e = e + 1;
            f = m[46:24];
        end else begin
            f = m[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 1'b1, 1'b0};
        if (e <= 0)   return {s, 31'd0, 1'b0, 1'b1};
        return {s, e[7:0], f, 1'b0, 1'b0};
    endfunction

    // Multiplier models: output garbage until the operands have been valid for LAT cycles.
    always @(posedge clk) begin
        mc   <= mul_valid   ? ((mc == 4'd15)   ? mc   : mc + 4'd1)   : 4'd0;
        b_mc <= b_mul_valid ? ((b_mc == 4'd15) ? b_mc : b_mc + 4'd1) : 4'd0;
    end

    always_comb begin
        {mul_z, mul_ovrf, mul_udrf} = {32'hDEADBEEF, 2'b11};
        if (mul_valid) {mul_z, mul_ovrf, mul_udrf} = fmul(mul_x, mul_y);
        {b_mul_z, b_mul_ovrf, b_mul_udrf} = {32'hDEADBEEF, 2'b11};
        if (b_mul_valid && b_mc >= 4'd3) {b_mul_z, b_mul_ovrf, b_mul_udrf} = fmul(b_mul_x, b_mul_y);
    end

    function automatic exp_t mk(input logic [1:0] who, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [33:0] r;
        r = fmul(x, y);
        e.who = who;
        e.z = r[33:2];
        e.o = r[1];
        e.u = r[0];
        return e;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0; req_x = '0; req_y = '0; req_rmode = '0;
        b_req_valid = '0; b_rsp_ready = '0; b_req_x = '0; b_req_y = '0; b_req_rmode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, mul_valid, mul_x, mul_y, mul_rmode, rsp_z, rsp_ovrf, rsp_udrf} !== '0) begin
            errs++;
            $display("FAIL reset_a: rv=%b mv=%b mx=%h z=%h", rsp_valid, mul_valid, mul_x, rsp_z);
        end
        checks++;
        if ({b_req_ready, b_rsp_valid, b_mul_valid, b_mul_x, b_mul_y, b_mul_rmode, b_rsp_z, b_rsp_ovrf, b_rsp_udrf} !== '0) begin
            errs++;
            $display("FAIL reset_b: rv=%b mv=%b mx=%h z=%h", b_rsp_valid, b_mul_valid, b_mul_x, b_rsp_z);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_contention;
        exp_t e;
        @(negedge clk);
        req_valid = 2'b11;
        req_x[0] = 32'h40000000; req_y[0] = 32'h40400000; req_rmode[0] = 3'd1;
        req_x[1] = 32'h3F800000; req_y[1] = 32'hBF800000; req_rmode[1] = 3'd2;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL cont_first_grant: got %b want 01", req_ready); end
        sb.push_back(mk(2'b01, req_x[0], req_y[0]));
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errs++; $display("FAIL cont_busy_ready: got %b want 00", req_ready); end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf} !== {e.who, e.z, e.o, e.u} || rsp_z !== 32'h40C00000) begin
            errs++;
            $display("FAIL cont_rsp0: got %b %h %b%b want %b 40c00000 %b%b", rsp_valid, rsp_z, rsp_ovrf, rsp_udrf, e.who, e.o, e.u);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errs++; $display("FAIL cont_second_grant: got %b want 10", req_ready); end
        sb.push_back(mk(2'b10, req_x[1], req_y[1]));
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf} !== {e.who, e.z, e.o, e.u} || rsp_z !== 32'hBF800000) begin
            errs++;
            $display("FAIL cont_rsp1: got %b %h want %b bf800000", rsp_valid, rsp_z, e.who);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL cont_ptr_back0: got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_single;
        exp_t e;
        @(negedge clk);
        req_valid = 2'b01;
        req_x[0] = 32'h3FC00000; req_y[0] = 32'h40000000; req_rmode[0] = 3'd0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL single_ready: got %b want 01", req_ready); end
        sb.push_back(mk(2'b01, req_x[0], req_y[0]));
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if (mul_valid !== 1'b1 || mul_x !== 32'h3FC00000 || mul_y !== 32'h40000000 || rsp_valid !== 2'b00) begin
            errs++;
            $display("FAIL single_busy: mv=%b mx=%h my=%h rv=%b want 1 3fc00000 40000000 00", mul_valid, mul_x, mul_y, rsp_valid);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf, mul_valid} !== {2'b01, 32'h40400000, 2'b00, 1'b0} || rsp_z !== e.z) begin
            errs++;
            $display("FAIL single_rsp: rv=%b z=%h f=%b%b mv=%b want 01 40400000 00 0", rsp_valid, rsp_z, rsp_ovrf, rsp_udrf, mul_valid);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        checks++;
        if (rsp_valid !== 2'b00) begin errs++; $display("FAIL single_consumed: rv=%b want 00", rsp_valid); end
    endtask

    task automatic test_backpressure;
        exp_t e;
        @(negedge clk);
        req_valid = 2'b10;
        req_x[1] = 32'h40400000; req_y[1] = 32'h40400000; req_rmode[1] = 3'd5;
        sb.push_back(mk(2'b10, req_x[1], req_y[1]));
        @(negedge clk);
        req_valid = 2'b01;
        req_x[0] = 32'h7F000000; req_y[0] = 32'h7F000000; req_rmode[0] = 3'd3;
        rsp_ready = 2'b01;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rsp_valid !== 2'b10 || rsp_z !== 32'h41100000 || req_ready !== 2'b00) begin
                errs++;
                $display("FAIL bp_stall%0d: rv=%b z=%h rr=%b want 10 41100000 00", k, rsp_valid, rsp_z, req_ready);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf} !== {e.who, e.z, e.o, e.u}) begin
            errs++;
            $display("FAIL bp_rsp: got %b %h want %b %h", rsp_valid, rsp_z, e.who, e.z);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL bp_release: rr=%b want 01", req_ready); end
        sb.push_back(mk(2'b01, req_x[0], req_y[0]));
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf} !== {e.who, e.z, e.o, e.u} || {rsp_z, rsp_ovrf} !== {32'h7F800000, 1'b1}) begin
            errs++;
            $display("FAIL ovrf: got %b %h o=%b want 01 7f800000 o=1", rsp_valid, rsp_z, rsp_ovrf);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errs++; $display("FAIL bp_ptr_to1: got %b want 10", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_passthrough;
        exp_t e;
        @(negedge clk);
        req_valid = 2'b10;
        req_x[1] = 32'h7FC00001; req_y[1] = 32'hFF800000; req_rmode[1] = 3'd7;
        sb.push_back(mk(2'b10, req_x[1], req_y[1]));
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({mul_x, mul_y, mul_rmode} !== {32'h7FC00001, 32'hFF800000, 3'd7}) begin
            errs++;
            $display("FAIL nan_pass: got %h %h %0d want 7fc00001 ff800000 7", mul_x, mul_y, mul_rmode);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf} !== {e.who, e.z, e.o, e.u}) begin
            errs++;
            $display("FAIL nan_rsp: got %b %h want %b %h", rsp_valid, rsp_z, e.who, e.z);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        req_x[1] = 32'h00000001; req_y[1] = 32'h3F800000; req_rmode[1] = 3'd0;
        sb.push_back(mk(2'b10, req_x[1], req_y[1]));
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf} !== {e.who, e.z, e.o, e.u} || rsp_z[30:0] !== 31'd0) begin
            errs++;
            $display("FAIL subnormal: got %b %h u=%b want %b %h u=%b", rsp_valid, rsp_z, rsp_udrf, e.who, e.z, e.u);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        @(negedge clk);
        req_valid = 2'b01;
        req_x[0] = 32'h40A00000; req_y[0] = 32'h40A00000; req_rmode[0] = 3'd4;
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if (mul_valid !== 1'b1) begin errs++; $display("FAIL rmid_busy: mv=%b want 1", mul_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({req_ready, rsp_valid, mul_valid, mul_x, mul_y, mul_rmode, rsp_z, rsp_ovrf, rsp_udrf} !== '0) begin
            errs++;
            $display("FAIL rmid_zero: rv=%b mv=%b mx=%h z=%h want all 0", rsp_valid, mul_valid, mul_x, rsp_z);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rmid_dropped%0d: rv=%b want 00", k, rsp_valid); end
        end
        req_valid = 2'b11;
        req_x[0] = 32'h40A00000; req_y[0] = 32'h3F000000; req_rmode[0] = 3'd0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL rmid_ptr0: got %b want 01", req_ready); end
        sb.push_back(mk(2'b01, req_x[0], req_y[0]));
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf} !== {e.who, e.z, e.o, e.u} || rsp_z !== 32'h40200000) begin
            errs++;
            $display("FAIL rmid_next: got %b %h want 01 40200000", rsp_valid, rsp_z);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
    endtask

    task automatic test_latency;
        exp_t e;
        @(negedge clk);
        b_req_valid = 2'b01;
        b_req_x[0] = 32'h40000000; b_req_y[0] = 32'h40000000; b_req_rmode[0] = 3'd3;
        #1;
        checks++;
        if (b_req_ready !== 2'b01) begin errs++; $display("FAIL lat_ready: got %b want 01", b_req_ready); end
        sb_b.push_back(mk(2'b01, b_req_x[0], b_req_y[0]));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            b_req_valid = 2'b00;
            b_req_x[0] = 32'h12345678;
            checks++;
            if ({b_mul_valid, b_mul_x, b_mul_y, b_mul_rmode, b_rsp_valid} !== {1'b1, 32'h40000000, 32'h40000000, 3'd3, 2'b00}) begin
                errs++;
                $display("FAIL lat_busy%0d: mv=%b mx=%h rm=%0d rv=%b", k, b_mul_valid, b_mul_x, b_mul_rmode, b_rsp_valid);
            end
        end
        @(negedge clk);
        e = sb_b.pop_front();
        checks++;
        if ({b_mul_valid, b_rsp_valid, b_rsp_z, b_rsp_ovrf, b_rsp_udrf} !== {1'b0, e.who, e.z, e.o, e.u} || b_rsp_z !== 32'h40800000) begin
            errs++;
            $display("FAIL lat_rsp: mv=%b rv=%b z=%h want 0 01 40800000", b_mul_valid, b_rsp_valid, b_rsp_z);
        end
        b_rsp_ready = 2'b01;
        @(negedge clk);
        b_rsp_ready = 2'b00;
        checks++;
        if (b_rsp_valid !== 2'b00) begin errs++; $display("FAIL lat_consumed: rv=%b want 00", b_rsp_valid); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   i;
        for (int n = 0; n < 8; n++) begin
            i = int'($urandom_range(0, 1));
            @(negedge clk);
            req_valid = 2'b00;
            req_valid[i] = 1'b1;
            req_x[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            req_y[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            req_rmode[i] = 3'($urandom);
            #1;
            checks++;
            if (req_ready !== req_valid) begin errs++; $display("FAIL b2b_ready%0d: got %b want %b", n, req_ready, req_valid); end
            sb.push_back(mk(req_valid, req_x[i], req_y[i]));
            @(negedge clk);
            req_valid = 2'b00;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf} !== {e.who, e.z, e.o, e.u}) begin
                errs++;
                $display("FAIL b2b_rsp%0d: got %b %h %b%b want %b %h %b%b", n, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf, e.who, e.z, e.o, e.u);
            end
            rsp_ready = e.who;
        end
        @(negedge clk);
        rsp_ready = 2'b00;
        checks++;
        if (sb.size() != 0 || rsp_valid !== 2'b00) begin
            errs++;
            $display("FAIL b2b_drain: left=%0d rv=%b want 0 00", sb.size(), rsp_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_passthrough();
        test_reset_mid();
        test_latency();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares one floating-point multiplier between two requesters. Each requester issues an operand pair and rounding mode over a valid/ready handshake, and the block grants the multiplier to one requester at a time by round-robin. It holds the operands stable for a fixed latency, captures the result and the overflow/underflow flags, and returns them over a per-requester valid/ready response channel. It sits between the issue logic and the FP multiplier datapath; the multiplier itself is instantiated by the parent and connected through the `mul_*` ports.

## Interface
Parameters:
- `MUL_LAT`, default 1: cycles from operands presented to multiplier result valid. Legal range 1..15.

Ports (index `i` is 0 or 1; vectors are packed with requester 1 in the upper slice):
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 2: requester `i` presents an operation.
- `req_ready` out 2: operation of requester `i` accepted this cycle.
- `req_x`, `req_y` in 2x32: IEEE-754 single-precision operands.
- `req_rmode` in 2x3: rounding mode.
- `rsp_valid` out 2: result for requester `i` available.
- `rsp_ready` in 2: requester `i` consumes the result.
- `rsp_z` out 32: result, shared by both response channels.
- `rsp_ovrf`, `rsp_udrf` out 1: flags, shared by both response channels.
- `mul_valid` out 1: `mul_x`, `mul_y` and `mul_rmode` are valid.
- `mul_x`, `mul_y` out 32: multiplier operands.
- `mul_rmode` out 3: multiplier rounding mode.
- `mul_z` in 32: multiplier result.
- `mul_ovrf`, `mul_udrf` in 1: multiplier flags.

## Operation
- State machine with three states: IDLE, BUSY, DONE. Also held:
  - `cnt`, 4 bits, counts down the multiplier latency.
  - `owner`, 1 bit, the requester being served.
  - `ptr`, 1 bit, the round-robin priority.
- IDLE:
  - Grant `g`: if both `req_valid` bits are high, `g = ptr`; otherwise `g` is the single requester with `req_valid` high.
  - `req_ready[g] = req_valid[g]`. This is combinational and asserted only in IDLE; the other `req_ready` bit is 0.
  - On the handshake edge: latch `req_x[g]`, `req_y[g]`, `req_rmode[g]` into the `mul_*` registers; set `owner = g` and `cnt = MUL_LAT`; go to BUSY.
- BUSY:
  - `mul_valid = 1`. Operands are held constant.
  - Each edge decrements `cnt`.
  - On the edge where `cnt == 1`: capture `mul_z`, `mul_ovrf` and `mul_udrf` into the `rsp_*` registers, then go to DONE.
- DONE:
  - `rsp_valid[owner] = 1`; the other bit is 0. `mul_valid = 0`.
  - When `rsp_ready[owner]` is high: go to IDLE and set `ptr = ~owner`.
- `rsp_ready` is ignored while the matching `rsp_valid` is 0.
- `req_valid` is ignored outside IDLE. Only one operation is in flight at a time.
- Operand values, including NaN, Inf, zero and subnormal, are passed through unmodified. Special-case handling belongs to the multiplier.
- The `rsp_*` registers and the `mul_x`, `mul_y`, `mul_rmode` registers keep their values until next overwritten.

## Timing
- Reset, applied on any edge with `rst_n` low, including mid-operation:
  - state = IDLE; `ptr`, `owner`, `cnt` = 0.
  - All outputs are 0: `req_ready`, `rsp_valid`, `mul_valid`, `mul_x`, `mul_y`, `mul_rmode`, `rsp_z`, `rsp_ovrf`, `rsp_udrf`.
  - An in-flight operation is dropped with no response.
- Accept at edge T:
  - `mul_valid` is high in cycles T+1 .. T+MUL_LAT.
  - The result is captured at edge T+MUL_LAT.
  - `rsp_valid` is high from cycle T+MUL_LAT+1.
- Response consumed at edge R: the block is in IDLE at R+1 and can accept again at edge R+1.
- Minimum initiation interval is `MUL_LAT + 2` cycles.
- A held-low `rsp_ready` stalls the block in DONE indefinitely. No new request is accepted during the stall.

## Structure
- Package `fp_mul_pkg` holds:
  - `fp32_t` (32-bit logic).
  - `rmode_t` (3-bit).
  - `arb_state_e` enum {IDLE, BUSY, DONE}.
  - `MUL_LAT_MAX = 15`.
- Sub-module `rr_arb2`: combinational two-way round-robin grant. Inputs `req[1:0]` and `ptr`; outputs `gnt[1:0]`, one-hot or zero.
- The multiplier is not instantiated here.

## Test plan
Benches connect the team FP multiplier, with `MUL_LAT = 1` unless stated.
- Single request: requester 0 sends 0x3FC00000 × 0x40000000, rmode 0, accepted at edge 0 → `rsp_valid[0]` high in cycle 2, `rsp_z = 0x40400000`, flags 0, `rsp_valid[1] = 0`.
- Contention: both requesters valid at once after reset → requester 0 granted first. After its response, requester 1 is granted, and `ptr` is back to 0.
- Backpressure: hold `rsp_ready[1] = 0` for 10 cycles → `rsp_valid[1]` and `rsp_z` stay stable; `req_ready` stays 0 even with `req_valid[0]` high.
- Latency parameter: `MUL_LAT = 4` → `mul_valid` high for exactly 4 cycles and `rsp_valid` at accept + 5; operands unchanged throughout.
- Reset mid-operation: drop `rst_n` low for one edge while in BUSY → all outputs 0 next cycle, no `rsp_valid`, next request serviced normally.
- Flag and pass-through: 0x7F000000 × 0x7F000000 → `rsp_ovrf = 1`. Subnormal 0x00000001 × 0x3F800000 → `rsp_z[30:0] = 0`.
